// File: rtl/hilo_muldiv_unit_pkg.sv
// Shared definitions for the HI/LO multiply-divide unit: execute codes,
// mult/div op encodings and FSM state encodings.
package hilo_muldiv_unit_pkg;

  typedef enum logic [5:0] {
    EXE_MTHI  = 6'h11,
    EXE_MTLO  = 6'h13,
    EXE_MULT  = 6'h18,
    EXE_MULTU = 6'h19,
    EXE_DIV   = 6'h1a,
    EXE_DIVU  = 6'h1b
  } exe_code_e;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } muldiv_op_e;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    MUL_WAIT = 2'd1,
    DIV_WAIT = 2'd2
  } muldiv_state_e;

  // Wide enough for the largest legal multiplier latency minus one.
  localparam int CNT_W = 4;

  function automatic logic op_is_div(muldiv_op_e op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

  function automatic logic op_is_signed(muldiv_op_e op);
    return (op == OP_MULT) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/hilo_muldiv_unit_mult.sv
// Pipelined signed/unsigned multiplier: operands registered on entry, product
// delivered MUL_LAT edges after in_valid, flush kills every stage in flight.
module muldiv_pipe_mult #(
  parameter int DATA_W  = 32,
  parameter int MUL_LAT = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic                  in_signed,
  input  logic [DATA_W-1:0]     a,
  input  logic [DATA_W-1:0]     b,
  input  logic                  flush,
  output logic                  out_valid,
  output logic [2*DATA_W-1:0]   product
);

  logic                s1_valid;
  logic                s1_signed;
  logic [DATA_W-1:0]   s1_a;
  logic [DATA_W-1:0]   s1_b;
  logic [2*DATA_W-1:0] ext_a;
  logic [2*DATA_W-1:0] ext_b;
  logic [2*DATA_W-1:0] s1_prod;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_valid  <= 1'b0;
      s1_signed <= 1'b0;
      s1_a      <= '0;
      s1_b      <= '0;
    end else begin
      s1_valid <= in_valid & ~flush;
      if (in_valid) begin
        s1_signed <= in_signed;
        s1_a      <= a;
        s1_b      <= b;
      end
    end
  end

  // Sign- or zero-extend to full width; the low 2*DATA_W bits of the product
  // are then correct for both signed and unsigned operands.
  always_comb begin
    ext_a   = {{DATA_W{s1_signed & s1_a[DATA_W-1]}}, s1_a};
    ext_b   = {{DATA_W{s1_signed & s1_b[DATA_W-1]}}, s1_b};
    s1_prod = ext_a * ext_b;
  end

  generate
    if (MUL_LAT == 1) begin : g_single
      assign out_valid = s1_valid;
      assign product   = s1_prod;
    end else begin : g_pipe
      localparam int DEPTH = MUL_LAT - 1;
      logic [DEPTH-1:0]    pv;
      logic [2*DATA_W-1:0] pp [DEPTH];

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          pv <= '0;
          for (int i = 0; i < DEPTH; i++) pp[i] <= '0;
        end else begin
          pv[0] <= s1_valid & ~flush;
          pp[0] <= s1_prod;
          for (int i = 1; i < DEPTH; i++) begin
            pv[i] <= pv[i-1] & ~flush;
            pp[i] <= pp[i-1];
          end
        end
      end

      assign out_valid = pv[DEPTH-1];
      assign product   = pp[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/hilo_muldiv_unit.sv
// HI/LO register file with multiply/divide sequencing: drives an internal
// pipelined multiplier and an external divider, and stalls the front end.
module hilo_muldiv_unit
  import hilo_muldiv_unit_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int MUL_LAT = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic [1:0]        req_op,
  input  logic [DATA_W-1:0] src_a,
  input  logic [DATA_W-1:0] src_b,
  input  logic              hi_we,
  input  logic              lo_we,
  input  logic [DATA_W-1:0] wdata,
  input  logic              flush,
  output logic              div_start,
  output logic              div_signed,
  output logic [DATA_W-1:0] div_a,
  output logic [DATA_W-1:0] div_b,
  output logic              div_annul,
  input  logic              div_valid,
  input  logic [DATA_W-1:0] div_quot,
  input  logic [DATA_W-1:0] div_rem,
  output logic              stall,
  output logic [DATA_W-1:0] hi,
  output logic [DATA_W-1:0] lo
);

  muldiv_state_e       state;
  muldiv_state_e       next_state;
  muldiv_op_e          op;
  logic [CNT_W-1:0]    lat_cnt;
  logic                accept;
  logic                accept_mul;
  logic                accept_div;
  logic                mul_done;
  logic                div_done;
  logic                mul_out_valid;
  logic [2*DATA_W-1:0] mul_product;
  logic                mul_write;

  assign op        = muldiv_op_e'(req_op);
  assign mul_write = (state == MUL_WAIT) & mul_done & mul_out_valid & ~flush;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= next_state;
  end

  // A divide by zero is accepted (one stall cycle) but never leaves IDLE.
  always_comb begin
    next_state = state;
    accept     = 1'b0;
    accept_mul = 1'b0;
    accept_div = 1'b0;
    mul_done   = 1'b0;
    div_done   = 1'b0;
    case (state)
      IDLE: begin
        if (req_valid && !flush) begin
          accept = 1'b1;
          if (!op_is_div(op)) begin
            accept_mul = 1'b1;
            next_state = MUL_WAIT;
          end else if (src_b != '0) begin
            accept_div = 1'b1;
            next_state = DIV_WAIT;
          end
        end
      end
      MUL_WAIT: begin
        mul_done = (lat_cnt == '0);
        if (flush || mul_done) next_state = IDLE;
      end
      DIV_WAIT: begin
        div_done = div_valid;
        if (flush || div_valid) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
    stall = rst & (accept | ((state != IDLE) & ~(mul_done | div_done)));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lat_cnt <= '0;
    end else if (accept_mul) begin
      lat_cnt <= CNT_W'(MUL_LAT - 1);
    end else if (state == MUL_WAIT && lat_cnt != '0) begin
      lat_cnt <= lat_cnt - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_start  <= 1'b0;
      div_annul  <= 1'b0;
      div_signed <= 1'b0;
      div_a      <= '0;
      div_b      <= '0;
    end else begin
      div_start <= accept_div;
      div_annul <= (state == DIV_WAIT) & flush;
      if (accept_div) begin
        div_signed <= op_is_signed(op);
        div_a      <= src_a;
        div_b      <= src_b;
      end
    end
  end

  // MT writes land in IDLE only; a result completing later overwrites them.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hi <= '0;
      lo <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (hi_we) hi <= wdata;
          if (lo_we) lo <= wdata;
        end
        MUL_WAIT: begin
          if (mul_write) {hi, lo} <= mul_product;
        end
        DIV_WAIT: begin
          if (div_valid && !flush) begin
            hi <= div_rem;
            lo <= div_quot;
          end
        end
        default: ;
      endcase
    end
  end

  muldiv_pipe_mult #(
    .DATA_W  (DATA_W),
    .MUL_LAT (MUL_LAT)
  ) u_mult (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (accept_mul),
    .in_signed (op_is_signed(op)),
    .a         (src_a),
    .b         (src_b),
    .flush     (flush),
    .out_valid (mul_out_valid),
    .product   (mul_product)
  );

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Self-checking bench for hilo_muldiv_unit: random and directed mult/div/MT
// traffic against an arithmetic HI/LO model, with the bench acting as divider.
module tb_hilo_muldiv_unit;

  localparam int W   = 32;
  localparam int LAT = 2;

  logic         clk = 1'b0;
  logic         rst;
  logic         req_valid;
  logic [1:0]   req_op;
  logic [W-1:0] src_a, src_b;
  logic         hi_we, lo_we;
  logic [W-1:0] wdata;
  logic         flush;
  logic         div_start, div_signed, div_annul;
  logic [W-1:0] div_a, div_b;
  logic         div_valid;
  logic [W-1:0] div_quot, div_rem;
  logic         stall;
  logic [W-1:0] hi, lo;

  int vectors     = 0;
  int miscompares = 0;
  logic [W-1:0] m_hi, m_lo;

  always #5 clk = ~clk;

  hilo_muldiv_unit #(.DATA_W(W), .MUL_LAT(LAT)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_op     (req_op),
    .src_a      (src_a),
    .src_b      (src_b),
    .hi_we      (hi_we),
    .lo_we      (lo_we),
    .wdata      (wdata),
    .flush      (flush),
    .div_start  (div_start),
    .div_signed (div_signed),
    .div_a      (div_a),
    .div_b      (div_b),
    .div_annul  (div_annul),
    .div_valid  (div_valid),
    .div_quot   (div_quot),
    .div_rem    (div_rem),
    .stall      (stall),
    .hi         (hi),
    .lo         (lo)
  );

  function automatic logic [63:0] ref_mul(logic [1:0] op, logic [W-1:0] a, logic [W-1:0] b);
    longint sa, sb;
    longint unsigned ua, ub;
    if (op == 2'b00) begin
      sa = $signed(a);
      sb = $signed(b);
      return sa * sb;
    end
    ua = a;
    ub = b;
    return ua * ub;
  endfunction

  task automatic ref_div(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         output logic [W-1:0] q, output logic [W-1:0] r);
    int sa, sb;
    sa = a;
    sb = b;
    if (op == 2'b10) begin
      q = sa / sb;
      r = sa % sb;
    end else begin
      q = a / b;
      r = a % b;
    end
  endtask

  task automatic idle_inputs();
    req_valid = 1'b0; req_op = 2'b00; src_a = '0; src_b = '0;
    hi_we = 1'b0; lo_we = 1'b0; wdata = '0; flush = 1'b0;
    div_valid = 1'b0; div_quot = '0; div_rem = '0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    idle_inputs();
    req_valid = 1'b1;
    #12;
    vectors++; if (stall !== 1'b0) begin miscompares++; $display("FAIL reset_stall got=%b exp=0", stall); end
    vectors++; if ({hi, lo} !== 64'h0) begin miscompares++; $display("FAIL reset_hilo got=%h exp=0", {hi, lo}); end
    vectors++; if ({div_start, div_annul, div_signed, div_a, div_b} !== '0) begin
      miscompares++; $display("FAIL reset_div got=%b%b%b %h %h exp=0", div_start, div_annul, div_signed, div_a, div_b);
    end
    @(negedge clk);
    req_valid = 1'b0;
    rst = 1'b1;
    m_hi = '0;
    m_lo = '0;
  endtask

  task automatic test_mult();
    logic [1:0]  op;
    logic [W-1:0] a, b;
    logic [63:0] p;
    int ncyc;
    for (int i = 0; i < 14; i++) begin
      case (i)
        0: begin op = 2'b00; a = 32'hFFFFFFFD; b = 32'd5; end
        1: begin op = 2'b01; a = 32'hFFFFFFFF; b = 32'd2; end
        2: begin op = 2'b00; a = 32'h80000000; b = 32'h80000000; end
        3: begin op = 2'b01; a = 32'hFFFFFFFF; b = 32'hFFFFFFFF; end
        default: begin op = 2'($urandom_range(0, 1)); a = $urandom; b = $urandom; end
      endcase
      p = ref_mul(op, a, b);
      @(negedge clk);
      req_valid = 1'b1; req_op = op; src_a = a; src_b = b;
      ncyc = 0;
      for (int c = 0; c < 20; c++) begin
        #1;
        if (!stall) break;
        ncyc++;
        @(negedge clk);
        req_valid = 1'b0;
      end
      req_valid = 1'b0;
      vectors++; if (ncyc != LAT) begin miscompares++; $display("FAIL mult_stall_cycles[%0d] got=%0d exp=%0d", i, ncyc, LAT); end
      vectors++; if ({hi, lo} !== {m_hi, m_lo}) begin miscompares++; $display("FAIL mult_early[%0d] got=%h exp=%h", i, {hi, lo}, {m_hi, m_lo}); end
      @(negedge clk);
      #1;
      {m_hi, m_lo} = p;
      vectors++; if ({hi, lo} !== p) begin miscompares++; $display("FAIL mult_result[%0d] got=%h exp=%h", i, {hi, lo}, p); end
    end
  endtask

  task automatic test_div();
    logic [1:0]  op;
    logic [W-1:0] a, b, q, r;
    int dly;
    for (int i = 0; i < 8; i++) begin
      if (i == 0) begin
        op = 2'b10; a = 32'hFFFFFFF9; b = 32'd2; dly = 10;
      end else begin
        op = 2'($urandom_range(2, 3)); a = $urandom; b = $urandom; dly = $urandom_range(1, 12);
        if (b == '0) b = 32'd1;
        if (op == 2'b10 && b == 32'hFFFFFFFF) b = 32'd3;
      end
      ref_div(op, a, b, q, r);
      @(negedge clk);
      req_valid = 1'b1; req_op = op; src_a = a; src_b = b;
      #1;
      vectors++; if ({stall, div_start} !== 2'b10) begin miscompares++; $display("FAIL div_accept[%0d] stall,start got=%b%b exp=10", i, stall, div_start); end
      @(negedge clk);
      req_valid = 1'b0;
      #1;
      vectors++; if ({div_start, div_signed, div_a, div_b} !== {1'b1, op == 2'b10, a, b}) begin
        miscompares++; $display("FAIL div_launch[%0d] got=%b%b %h %h exp=1%b %h %h", i, div_start, div_signed, div_a, div_b, op == 2'b10, a, b);
      end
      for (int c = 1; c < dly; c++) begin
        @(negedge clk);
        #1;
        vectors++; if ({stall, div_start} !== 2'b10) begin miscompares++; $display("FAIL div_wait[%0d] stall,start got=%b%b exp=10", i, stall, div_start); end
      end
      @(negedge clk);
      div_valid = 1'b1; div_quot = q; div_rem = r;
      #1;
      vectors++; if (stall !== 1'b0) begin miscompares++; $display("FAIL div_done_stall[%0d] got=%b exp=0", i, stall); end
      @(negedge clk);
      div_valid = 1'b0;
      #1;
      m_hi = r; m_lo = q;
      vectors++; if ({hi, lo, stall} !== {r, q, 1'b0}) begin miscompares++; $display("FAIL div_result[%0d] got=%h %b exp=%h 0", i, {hi, lo}, stall, {r, q}); end
    end
  endtask

  task automatic test_div_zero();
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      req_valid = 1'b1; req_op = (i == 0) ? 2'b11 : 2'b10; src_a = $urandom; src_b = '0;
      #1;
      vectors++; if (stall !== 1'b1) begin miscompares++; $display("FAIL divzero_stall[%0d] got=%b exp=1", i, stall); end
      @(negedge clk);
      req_valid = 1'b0;
      #1;
      vectors++; if ({stall, div_start} !== 2'b00) begin miscompares++; $display("FAIL divzero_after[%0d] stall,start got=%b%b exp=00", i, stall, div_start); end
      @(negedge clk);
      #1;
      vectors++; if ({div_start, hi, lo} !== {1'b0, m_hi, m_lo}) begin miscompares++; $display("FAIL divzero_hilo[%0d] got=%b %h exp=0 %h", i, div_start, {hi, lo}, {m_hi, m_lo}); end
    end
  endtask

  task automatic test_flush();
    @(negedge clk);
    req_valid = 1'b1; req_op = 2'b10; src_a = 32'd100; src_b = 32'd7;
    @(negedge clk);
    req_valid = 1'b0;
    repeat (2) @(negedge clk);
    flush = 1'b1; div_valid = 1'b1; div_quot = $urandom; div_rem = $urandom;
    #1;
    vectors++; if (div_annul !== 1'b0) begin miscompares++; $display("FAIL flush_div_annul_early got=%b exp=0", div_annul); end
    @(negedge clk);
    flush = 1'b0; div_valid = 1'b0;
    #1;
    vectors++; if ({div_annul, stall, hi, lo} !== {2'b10, m_hi, m_lo}) begin
      miscompares++; $display("FAIL flush_div got annul=%b stall=%b hilo=%h exp 1 0 %h", div_annul, stall, {hi, lo}, {m_hi, m_lo});
    end
    @(negedge clk);
    div_valid = 1'b1; div_quot = $urandom; div_rem = $urandom;
    #1;
    vectors++; if (div_annul !== 1'b0) begin miscompares++; $display("FAIL flush_div_annul_width got=%b exp=0", div_annul); end
    @(negedge clk);
    div_valid = 1'b0;
    #1;
    vectors++; if ({hi, lo} !== {m_hi, m_lo}) begin miscompares++; $display("FAIL stray_div_valid got=%h exp=%h", {hi, lo}, {m_hi, m_lo}); end
    @(negedge clk);
    req_valid = 1'b1; req_op = 2'b00; src_a = $urandom; src_b = $urandom;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    #1;
    vectors++; if ({stall, div_annul, hi, lo} !== {2'b00, m_hi, m_lo}) begin
      miscompares++; $display("FAIL flush_mult got stall=%b annul=%b hilo=%h exp 0 0 %h", stall, div_annul, {hi, lo}, {m_hi, m_lo});
    end
    @(negedge clk);
    req_valid = 1'b1; flush = 1'b1; req_op = 2'b01; src_a = $urandom; src_b = $urandom;
    #1;
    vectors++; if (stall !== 1'b0) begin miscompares++; $display("FAIL flush_blocks_accept got=%b exp=0", stall); end
    @(negedge clk);
    req_valid = 1'b0; flush = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    vectors++; if ({stall, hi, lo} !== {1'b0, m_hi, m_lo}) begin miscompares++; $display("FAIL flush_idle got=%b %h exp=0 %h", stall, {hi, lo}, {m_hi, m_lo}); end
  endtask

  task automatic test_mt();
    logic [W-1:0] w, a, b;
    logic [63:0] p;
    w = $urandom;
    @(negedge clk);
    hi_we = 1'b1; wdata = w;
    @(negedge clk);
    hi_we = 1'b0;
    #1;
    m_hi = w;
    vectors++; if ({hi, lo} !== {m_hi, m_lo}) begin miscompares++; $display("FAIL mthi_idle got=%h exp=%h", {hi, lo}, {m_hi, m_lo}); end
    a = $urandom; b = $urandom;
    p = ref_mul(2'b01, a, b);
    @(negedge clk);
    req_valid = 1'b1; req_op = 2'b01; src_a = a; src_b = b;
    @(negedge clk);
    req_valid = 1'b0; lo_we = 1'b1; wdata = 32'h12345678;
    @(negedge clk);
    lo_we = 1'b0;
    #1;
    vectors++; if (lo !== m_lo) begin miscompares++; $display("FAIL mtlo_busy_ignored got=%h exp=%h", lo, m_lo); end
    @(negedge clk);
    #1;
    {m_hi, m_lo} = p;
    vectors++; if ({hi, lo} !== p) begin miscompares++; $display("FAIL mt_mult_result got=%h exp=%h", {hi, lo}, p); end
    @(negedge clk);
    lo_we = 1'b1; wdata = 32'h12345678;
    @(negedge clk);
    lo_we = 1'b0;
    #1;
    m_lo = 32'h12345678;
    vectors++; if ({hi, lo} !== {m_hi, m_lo}) begin miscompares++; $display("FAIL mtlo_idle got=%h exp=%h", {hi, lo}, {m_hi, m_lo}); end
    w = $urandom; a = $urandom; b = $urandom;
    p = ref_mul(2'b00, a, b);
    @(negedge clk);
    hi_we = 1'b1; wdata = w; req_valid = 1'b1; req_op = 2'b00; src_a = a; src_b = b;
    @(negedge clk);
    hi_we = 1'b0; req_valid = 1'b0;
    #1;
    vectors++; if (hi !== w) begin miscompares++; $display("FAIL mt_with_accept got=%h exp=%h", hi, w); end
    repeat (2) @(negedge clk);
    #1;
    {m_hi, m_lo} = p;
    vectors++; if ({hi, lo} !== p) begin miscompares++; $display("FAIL mt_overwritten got=%h exp=%h", {hi, lo}, p); end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    req_valid = 1'b1; req_op = 2'b00; src_a = $urandom | 32'h1; src_b = $urandom | 32'h1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    vectors++; if ({stall, hi, lo} !== 65'h0) begin miscompares++; $display("FAIL reset_mid_mult got stall=%b hilo=%h exp 0 0", stall, {hi, lo}); end
    @(negedge clk);
    rst = 1'b1; req_valid = 1'b0;
    m_hi = '0; m_lo = '0;
    repeat (3) @(negedge clk);
    #1;
    vectors++; if ({stall, hi, lo} !== 65'h0) begin miscompares++; $display("FAIL reset_mid_discard got stall=%b hilo=%h exp 0 0", stall, {hi, lo}); end
    @(negedge clk);
    req_valid = 1'b1; req_op = 2'b11; src_a = $urandom; src_b = 32'd9;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    vectors++; if ({div_annul, div_start, stall} !== 3'b000) begin miscompares++; $display("FAIL reset_mid_div got=%b%b%b exp=000", div_annul, div_start, stall); end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    #1;
    vectors++; if ({div_annul, stall} !== 2'b00) begin miscompares++; $display("FAIL reset_mid_div_after got=%b%b exp=00", div_annul, stall); end
  endtask

  task automatic test_back_to_back();
    logic [1:0]  op;
    logic [W-1:0] a, b, q, r;
    logic [63:0] p;
    int kind, ncyc, dly;
    logic seen;
    for (int i = 0; i < 30; i++) begin
      kind = $urandom_range(0, 4);
      a = $urandom; b = $urandom;
      @(negedge clk);
      if (kind == 4) begin
        hi_we = 1'($urandom_range(0, 1)); lo_we = ~hi_we | 1'($urandom_range(0, 1)); wdata = a;
        if (hi_we) m_hi = a;
        if (lo_we) m_lo = a;
        @(negedge clk);
        hi_we = 1'b0; lo_we = 1'b0;
        #1;
        vectors++; if ({hi, lo} !== {m_hi, m_lo}) begin miscompares++; $display("FAIL b2b_mt[%0d] got=%h exp=%h", i, {hi, lo}, {m_hi, m_lo}); end
      end else if (kind <= 1) begin
        op = 2'(kind);
        p = ref_mul(op, a, b);
        req_valid = 1'b1; req_op = op; src_a = a; src_b = b;
        ncyc = 0;
        for (int c = 0; c < 20; c++) begin
          #1;
          if (!stall) break;
          ncyc++;
          @(negedge clk);
          req_valid = 1'b0;
        end
        req_valid = 1'b0;
        @(negedge clk);
        #1;
        {m_hi, m_lo} = p;
        vectors++; if (ncyc != LAT || {hi, lo} !== p) begin
          miscompares++; $display("FAIL b2b_mult[%0d] got cyc=%0d %h exp cyc=%0d %h", i, ncyc, {hi, lo}, LAT, p);
        end
      end else begin
        op = 2'(kind);
        if ($urandom_range(0, 3) == 0) b = '0;
        else if (b == '0 || b == 32'hFFFFFFFF) b = 32'd5;
        req_valid = 1'b1; req_op = op; src_a = a; src_b = b;
        @(negedge clk);
        req_valid = 1'b0;
        #1;
        if (b == '0) begin
          vectors++; if ({stall, div_start, hi, lo} !== {2'b00, m_hi, m_lo}) begin
            miscompares++; $display("FAIL b2b_divzero[%0d] got=%b%b %h exp=00 %h", i, stall, div_start, {hi, lo}, {m_hi, m_lo});
          end
        end else begin
          ref_div(op, a, b, q, r);
          seen = div_start;
          dly = $urandom_range(1, 4);
          repeat (dly) @(negedge clk);
          div_valid = 1'b1; div_quot = q; div_rem = r;
          @(negedge clk);
          div_valid = 1'b0;
          #1;
          m_hi = r; m_lo = q;
          vectors++; if (!seen || {stall, hi, lo} !== {1'b0, r, q}) begin
            miscompares++; $display("FAIL b2b_div[%0d] got start=%b stall=%b %h exp 1 0 %h", i, seen, stall, {hi, lo}, {r, q});
          end
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_mult();
    test_div();
    test_div_zero();
    test_flush();
    test_mt();
    test_reset_mid();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/hilo_muldiv_unit.md
HILO_MULDIV_UNIT -- requirements
Module: hilo_muldiv_unit

Interface
REQ-001 The module SHALL take parameter DATA_W, default 32, as the operand width and the width of HI and LO.
REQ-002 The module SHALL take parameter MUL_LAT, default 2, legal range 1..8, as the multiplier latency in cycles.
REQ-003 The module SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The module SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-005 The module SHALL have port req_valid, input, 1 bit: a mult/div instruction is in EX this cycle.
REQ-006 The module SHALL have port req_op, input, 2 bits: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
REQ-007 The module SHALL have ports src_a and src_b, input, DATA_W bits each: rs and rt operands.
REQ-008 The module SHALL have ports hi_we and lo_we, input, 1 bit each: MTHI and MTLO write enables.
REQ-009 The module SHALL have port wdata, input, DATA_W bits: MTHI/MTLO data.
REQ-010 The module SHALL have port flush, input, 1 bit: annuls any operation in flight.
REQ-011 The module SHALL have port div_start, output, 1 bit: one-cycle start pulse to the external divider.
REQ-012 The module SHALL have port div_signed, output, 1 bit: signed-divide select, valid while div_start is high.
REQ-013 The module SHALL have ports div_a and div_b, output, DATA_W bits each: registered dividend and divisor.
REQ-014 The module SHALL have port div_annul, output, 1 bit: one-cycle cancel pulse to the divider.
REQ-015 The module SHALL have port div_valid, input, 1 bit: divider result valid.
REQ-016 The module SHALL have ports div_quot and div_rem, input, DATA_W bits each: quotient and remainder.
REQ-017 The module SHALL have port stall, output, 1 bit: freeze the pipeline front end.
REQ-018 The module SHALL have ports hi and lo, output, DATA_W bits each: architectural HI and LO registers.

Function
REQ-019 The FSM SHALL have three states: IDLE, MUL_WAIT and DIV_WAIT.
REQ-020 A request SHALL be accepted only in IDLE when req_valid=1 and flush=0; req_valid outside IDLE SHALL be ignored.
REQ-021 stall SHALL be combinational: (IDLE & req_valid & ~flush) | (state != IDLE & ~done_this_cycle).
REQ-022 Accepting a MULT or MULTU SHALL go to MUL_WAIT, load the latency counter with MUL_LAT-1, and feed the pipelined multiplier.
REQ-023 MULT SHALL form a signed 2*DATA_W-bit product and MULTU an unsigned one.
REQ-024 A request accepted at edge E0 SHALL write {hi, lo} = product at edge E0+MUL_LAT and then return to IDLE.
REQ-025 Accepting a DIV or DIVU SHALL go to DIV_WAIT, register div_a/div_b/div_signed, and pulse div_start in the cycle after acceptance.
REQ-026 In DIV_WAIT with div_valid=1, the unit SHALL write hi=div_rem and lo=div_quot and return to IDLE on that edge.
REQ-027 A DIV or DIVU with src_b=0 SHALL not start the divider, SHALL leave HI/LO unchanged, and SHALL complete in 1 cycle (stall high for the accept cycle only).
REQ-028 flush=1 in MUL_WAIT or DIV_WAIT SHALL return the FSM to IDLE at the next edge with HI/LO unchanged.
REQ-029 flush=1 in DIV_WAIT SHALL also pulse div_annul for one cycle.
REQ-030 When flush and div_valid (or multiplier completion) occur in the same cycle, flush SHALL win and the result SHALL be discarded.
REQ-031 hi_we/lo_we SHALL update hi/lo with wdata only in IDLE; outside IDLE they SHALL be ignored.
REQ-032 When hi_we/lo_we and request acceptance occur in the same IDLE cycle, the MT write SHALL take effect and the later mult/div result SHALL overwrite it.
REQ-033 div_valid received outside DIV_WAIT SHALL be ignored.

Reset
REQ-034 rst=0 SHALL asynchronously force state=IDLE, hi=0, lo=0, div_start=0, div_annul=0, div_a=0, div_b=0, div_signed=0, the latency counter to 0, and all multiplier pipeline valid bits to 0.
REQ-035 stall SHALL be 0 while rst=0.
REQ-036 Reset mid-operation SHALL discard the operation without pulsing div_annul.

Structure
REQ-037 Op encodings (00..11) and FSM state encodings SHALL live in the shared defines header alongside the EXE_* codes.
REQ-038 The multiplier SHALL be one sub-module, muldiv_pipe_mult (parameters DATA_W and MUL_LAT; ports clk, rst, in_valid, in_signed, a, b, flush, out_valid, product).

Verification
REQ-039 MULT with src_a=-3 and src_b=5 (MUL_LAT=2) -> hi=0xFFFFFFFF, lo=0xFFFFFFF1 two edges after acceptance, stall high for exactly 2 cycles.
REQ-040 MULTU with src_a=0xFFFFFFFF and src_b=2 -> hi=0x00000001, lo=0xFFFFFFFE.
REQ-041 DIV with src_a=-7 and src_b=2, divider returning quot=-3 and rem=-1 after 10 cycles -> div_start high one cycle with div_signed=1, then hi=0xFFFFFFFF and lo=0xFFFFFFFD, stall low the cycle after.
REQ-042 DIVU with src_b=0 -> div_start stays 0, hi/lo unchanged, stall high for 1 cycle.
REQ-043 DIV in flight with flush=1 and div_valid=1 in the same cycle -> div_annul pulses once, hi/lo unchanged, FSM returns to IDLE.
REQ-044 MTLO with wdata=0x12345678 while in MUL_WAIT -> ignored; the same write in IDLE -> lo=0x12345678 next edge; rst=0 mid-MUL_WAIT -> hi=lo=0, stall=0 immediately.
